hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline. It handles the hazards the forwarding unit cannot resolve: load-use, data-memory wait, taken branch/jump resolved in MEM, and halt.
- Drives the PC enable and the enable/flush of each pipeline latch.
- A small FSM guarantees exactly one bubble per load-use and tracks d-cache waits, with a timeout watchdog.

Parameters:
- REG_W, 5, register-index width
- TIMEOUT, 255, max consecutive DWAIT cycles before mem_timeout asserts
- CNT_W, 32, perf counter width (used only with HAZARD_PERF_EN)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- id_rs  in  REG_W  rs of instruction in ID
- id_rt  in  REG_W  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_dren  in  1  instruction in EX is a load
- ex_dest  in  REG_W  destination register of EX instruction
- mem_dren  in  1  load in MEM
- mem_dwen  in  1  store in MEM
- mem_br_taken  in  1  branch/jump in MEM redirects PC
- wb_halt  in  1  halt instruction in WB
- pc_en  out  1  PC load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous bubble insert into the named latch
- halted  out  1  sticky halt indication
- mem_timeout  out  1  sticky d-cache watchdog flag
- stall_cnt, flush_cnt  out  CNT_W each  perf counters

Behaviour:
- Reset (RST=1, asynchronous):
  - state=RUN; all enables=0 and all flushes=0 while RST is high.
  - halted=0, mem_timeout=0, wait counter=0, perf counters=0.
- FSM states: RUN, LU_STALL, DWAIT, HALT. Outputs are combinational from state and inputs; state, counters and sticky flags are registered.
- Signal definitions:
  - dwait = (mem_dren|mem_dwen) & ~dhit
  - lu = ex_dren & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt))
- Priority each cycle in RUN or LU_STALL, highest first:
  1. wb_halt: all enables 0, flushes 0; next state HALT.
  2. dwait: all enables 0, flushes 0 (full freeze); next state DWAIT.
  3. mem_br_taken: pc_en=1 regardless of ihit; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1; next state RUN.
  4. lu, only in RUN: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; next state LU_STALL.
  5. ~ihit: pc_en=0, ifid_flush=1, other enables 1; next state RUN.
  6. Otherwise: all enables 1, flushes 0; next state RUN.
- LU_STALL: lu is ignored, so at most one bubble per load; the state always exits after 1 cycle.
- DWAIT:
  - While ~dhit, full freeze. Wait counter increments, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT, mem_timeout sets and stays set until reset.
  - On dhit, re-evaluate priorities 1,3,5,6 with the same outputs as RUN; clear the counter; next state follows those rules (lu is excluded, because the frozen ID/EX state was already checked).
  - wb_halt during DWAIT goes to HALT.
- HALT: all enables 0 and flushes 0 permanently; halted=1 from the cycle after entry; only RST exits.
- Enables take effect on the next CLK edge; a flush has priority over the enable of the same latch.
- Simultaneous events follow the priority order above, e.g.:
  - a branch and a load-use in the same cycle give a flush with no stall;
  - dwait and a branch in the same cycle give a freeze, and the branch is taken when dhit arrives.
- RST mid-DWAIT or mid-stall: immediate return to the reset values; no partial flush is retained.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with pc_en=0 outside HALT and reset.
  - flush_cnt increments on every cycle with any flush=1.
  - Both counters saturate at all-ones and clear on RST.
- Not defined: stall_cnt and flush_cnt are tied to 0; no counter registers exist.

Test Plan:
- Load-use: ex_dren=1, ex_dest=8, id_rs=8, ihit=1 -> 1 cycle with pc_en=0, ifid_en=0, idex_flush=1, then state RUN with all enables 1; exactly one bubble.
- Zero-register load: ex_dest=0, id_rs=0 -> no stall, all enables 1.
- D-cache wait: mem_dren=1, dhit=0 for 4 cycles then 1 -> all enables 0 for 4 cycles, normal advance on the 5th; mem_timeout stays 0.
- Timeout: dhit=0 held 260 cycles, TIMEOUT=255 -> mem_timeout=1 after cycle 255 and remains 1 after dhit returns; clears only on RST.
- Branch with load-use: mem_br_taken=1 and lu=1 with ihit=0 -> pc_en=1, ifid/idex/exmem flush=1, no LU_STALL.
- Halt then reset: wb_halt=1 -> halted=1 next cycle, all enables 0 for 10+ cycles; RST pulse -> halted=0, state RUN. With HAZARD_PERF_EN, counters read 0 after the reset.

Source files
------------

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use bubble, d-cache freeze, branch flush, halt.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise they read as zero.
module hazard_unit #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_dren,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             mem_br_taken,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        DWAIT    = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [WAIT_W-1:0] w_waitCntNext;
    logic              r_halted;
    logic              r_memTimeout;
    logic              w_dwait;
    logic              w_lu;
    logic              w_stillWaiting;

    assign w_dwait = (mem_dren | mem_dwen) & ~dhit;
    assign w_lu    = ex_dren & (ex_dest != '0) &
                     ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));

    // RUN, LU_STALL and DWAIT share one priority chain; load-use is only honoured from RUN,
    // which both limits it to one bubble and skips it when a d-cache wait releases.
    always_comb begin
        w_nextState = r_state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!RST) begin
            case (r_state)
                RUN, LU_STALL, DWAIT: begin
                    if (wb_halt) begin
                        w_nextState = HALT;
                    end else if (w_dwait) begin
                        w_nextState = DWAIT;
                    end else if (mem_br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        w_nextState = RUN;
                    end else if (w_lu && (r_state == RUN)) begin
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        idex_flush  = 1'b1;
                        w_nextState = LU_STALL;
                    end else if (!ihit) begin
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        w_nextState = RUN;
                    end else begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        w_nextState = RUN;
                    end
                end
                HALT: begin
                    w_nextState = HALT;
                end
                default: begin
                    w_nextState = RUN;
                end
            endcase
        end
    end

    // The watchdog only counts frozen cycles spent inside DWAIT and clears on any exit.
    assign w_stillWaiting = (r_state == DWAIT) && (w_nextState == DWAIT);

    always_comb begin
        w_waitCntNext = '0;
        if (w_stillWaiting) begin
            w_waitCntNext = (r_waitCnt == WAIT_MAX) ? r_waitCnt : r_waitCnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= RUN;
            r_waitCnt    <= '0;
            r_halted     <= 1'b0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_waitCntNext;
            if (w_nextState == HALT) begin
                r_halted <= 1'b1;
            end
            if (w_stillWaiting && (w_waitCntNext == WAIT_MAX)) begin
                r_memTimeout <= 1'b1;
            end
        end
    end

    assign halted      = r_halted;
    assign mem_timeout = r_memTimeout;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!pc_en && (r_state != HALT) && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if ((ifid_flush || idex_flush || exmem_flush) && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: each step pushes its expected control word, then pops and checks it.
module tb_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    // Control word layout: {pc, ifidEn, idexEn, exmemEn, memwbEn, ifidFl, idexFl, exmemFl, halted, timeout}
    localparam logic [9:0] FULL   = 10'b11111_111_11;
    localparam logic [9:0] ALL1   = 10'b11111_000_00;
    localparam logic [9:0] FRZ    = 10'b00000_000_00;
    localparam logic [9:0] LU_E   = 10'b00011_010_00;
    localparam logic [9:0] LU_M   = 10'b11011_111_11;
    localparam logic [9:0] MISS   = 10'b01111_100_00;
    localparam logic [9:0] BR_E   = 10'b10001_111_00;
    localparam logic [9:0] BR_M   = 10'b10001_111_11;
    localparam logic [9:0] HALTED = 10'b00000_000_10;

    typedef struct {
        string      name;
        logic [9:0] exp;
        logic [9:0] mask;
    } sb_t;

    sb_t sb[$];
    int  nTests = 0;
    int  nFail  = 0;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ihit, dhit, idUsesRt, exDren, memDren, memDwen, memBrTaken, wbHalt;
    logic [REG_W-1:0] idRs, idRt, exDest;
    logic             pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic             ifidFlush, idexFlush, exmemFlush, halted, memTimeout;
    logic [CNT_W-1:0] stallCnt, flushCnt;
    logic [9:0]       obs;

    hazard_unit #(.REG_W(REG_W), .TIMEOUT(255), .CNT_W(CNT_W)) dut (
        .CLK(clock), .RST(reset), .ihit(ihit), .dhit(dhit),
        .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
        .ex_dren(exDren), .ex_dest(exDest),
        .mem_dren(memDren), .mem_dwen(memDwen), .mem_br_taken(memBrTaken), .wb_halt(wbHalt),
        .pc_en(pcEn), .ifid_en(ifidEn), .idex_en(idexEn), .exmem_en(exmemEn), .memwb_en(memwbEn),
        .ifid_flush(ifidFlush), .idex_flush(idexFlush), .exmem_flush(exmemFlush),
        .halted(halted), .mem_timeout(memTimeout),
        .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    always #5 clock = ~clock;

    assign obs = {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, exmemFlush, halted, memTimeout};

    task automatic setIdle();
        ihit = 1'b1; dhit = 1'b1; idRs = '0; idRt = '0; idUsesRt = 1'b0;
        exDren = 1'b0; exDest = '0; memDren = 1'b0; memDwen = 1'b0;
        memBrTaken = 1'b0; wbHalt = 1'b0;
    endtask

    task automatic applyStimulus(input string nm, input logic [9:0] e, input logic [9:0] m);
        sb_t it;
        it.name = nm; it.exp = e; it.mask = m;
        sb.push_back(it);
    endtask

    task automatic test_reset();
        sb_t item;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            setIdle();
            if (k == 0) applyStimulus("reset_held", FRZ, FULL);
            else begin reset = 1'b0; applyStimulus("reset_release", ALL1, FULL); end
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
        nTests++;
        if (stallCnt !== '0 || flushCnt !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_counters: observed %0d/%0d expected 0/0", stallCnt, flushCnt);
        end
    endtask

    task automatic test_normal();
        sb_t item;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            setIdle();
            idRs = 5'(k + 3); idRt = 5'(k + 4); idUsesRt = 1'b1;
            exDren = (k != 1); exDest = 5'(k + 10);
            applyStimulus("normal_advance", ALL1, FULL);
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_load_use();
        sb_t item;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            setIdle();
            case (k)
                0: begin exDren = 1; exDest = 8; idRs = 8; applyStimulus("lu_rs_stall", LU_E, LU_M); end
                1: begin exDren = 1; exDest = 8; idRs = 8; applyStimulus("lu_single_bubble", ALL1, FULL); end
                2: applyStimulus("lu_resume", ALL1, FULL);
                3: begin exDren = 1; exDest = 9; idRs = 1; idRt = 9; idUsesRt = 1; applyStimulus("lu_rt_stall", LU_E, LU_M); end
                4: begin exDren = 1; exDest = 9; idRs = 1; idRt = 9; idUsesRt = 1; applyStimulus("lu_rt_single", ALL1, FULL); end
                default: begin exDren = 1; exDest = 9; idRs = 1; idRt = 9; idUsesRt = 0; applyStimulus("lu_rt_unused", ALL1, FULL); end
            endcase
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_zero_reg();
        sb_t item;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            setIdle();
            exDren = 1; exDest = 0; idRs = 0; idRt = 0; idUsesRt = (k == 1);
            applyStimulus("zero_reg_no_stall", ALL1, FULL);
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_imiss();
        sb_t item;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            setIdle();
            if (k < 2) begin ihit = 0; applyStimulus("imiss_bubble", MISS, FULL); end
            else applyStimulus("imiss_resume", ALL1, FULL);
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_dwait();
        sb_t item;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            setIdle();
            if (k < 4) begin memDren = 1; dhit = 0; applyStimulus("dwait_load_freeze", FRZ, FULL); end
            else if (k == 4) begin memDren = 1; applyStimulus("dwait_load_release", ALL1, FULL); end
            else if (k < 7) begin memDwen = 1; dhit = 0; applyStimulus("dwait_store_freeze", FRZ, FULL); end
            else if (k == 7) begin memDwen = 1; applyStimulus("dwait_store_release", ALL1, FULL); end
            else applyStimulus("dwait_idle", ALL1, FULL);
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_branch_lu();
        sb_t item;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            setIdle();
            exDren = (k < 3); exDest = 12; idRs = 12;
            case (k)
                0: begin ihit = 0; memBrTaken = 1; applyStimulus("branch_over_lu", BR_E, BR_M); end
                1: applyStimulus("lu_after_branch", LU_E, LU_M);
                2: applyStimulus("lu_after_branch_single", ALL1, FULL);
                default: applyStimulus("branch_idle", ALL1, FULL);
            endcase
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_dwait_branch();
        sb_t item;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            setIdle();
            if (k < 3) begin memDren = 1; memBrTaken = 1; exDren = 1; exDest = 4; idRs = 4; end
            if (k < 2) begin dhit = 0; applyStimulus("dwait_branch_freeze", FRZ, FULL); end
            else if (k == 2) applyStimulus("dwait_branch_taken", BR_E, BR_M);
            else applyStimulus("dwait_branch_idle", ALL1, FULL);
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_reset_midway();
        sb_t item;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            setIdle();
            case (k)
                0, 1: begin memDren = 1; dhit = 0; applyStimulus("mid_dwait_freeze", FRZ, FULL); end
                2: begin memDren = 1; dhit = 0; reset = 1; applyStimulus("mid_dwait_reset", FRZ, FULL); end
                3: begin reset = 0; applyStimulus("mid_dwait_after_reset", ALL1, FULL); end
                4: begin exDren = 1; exDest = 7; idRs = 7; applyStimulus("mid_stall_enter", LU_E, LU_M); end
                5: begin exDren = 1; exDest = 7; idRs = 7; reset = 1; applyStimulus("mid_stall_reset", FRZ, FULL); end
                6: begin exDren = 1; exDest = 7; idRs = 7; reset = 0; applyStimulus("mid_stall_after_reset", LU_E, LU_M); end
                default: applyStimulus("mid_stall_exit", ALL1, FULL);
            endcase
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    // Timeout flag is left unchecked for a few cycles around the saturation point.
    task automatic test_timeout();
        sb_t item;
        for (int k = 1; k <= 264; k++) begin
            @(negedge clock);
            setIdle();
            if (k <= 260) begin
                memDren = 1; dhit = 0;
                if (k <= 250) applyStimulus("timeout_not_yet", FRZ, FULL);
                else if (k < 258) applyStimulus("timeout_window", FRZ, 10'b11111_111_10);
                else applyStimulus("timeout_set", FRZ | 10'b1, FULL);
            end else begin
                memDren = (k == 261);
                applyStimulus("timeout_sticky", ALL1 | 10'b1, FULL);
            end
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
    endtask

    task automatic test_halt_reset();
        sb_t item;
        for (int k = 0; k < 17; k++) begin
            @(negedge clock);
            setIdle();
            if (k == 0) begin memDren = 1; dhit = 0; applyStimulus("halt_pre_dwait", FRZ | 10'b1, FULL); end
            else if (k == 1) begin memDren = 1; dhit = 0; wbHalt = 1; applyStimulus("halt_from_dwait", FRZ | 10'b1, FULL); end
            else if (k <= 12) begin memBrTaken = (k == 5); applyStimulus("halt_hold", HALTED | 10'b1, FULL); end
            else if (k == 13) begin reset = 1; applyStimulus("halt_reset", FRZ, FULL); end
            else if (k == 14) begin reset = 0; applyStimulus("halt_after_reset", ALL1, FULL); end
            else if (k == 15) begin wbHalt = 1; applyStimulus("halt_from_run", FRZ, FULL); end
            else applyStimulus("halt_from_run_hold", HALTED, FULL);
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
            if (k == 14) begin
                nTests++;
                if (stallCnt !== '0 || flushCnt !== '0) begin
                    nFail++;
                    $display("[TB] FAIL halt_counters_cleared: observed %0d/%0d expected 0/0", stallCnt, flushCnt);
                end
            end
        end
    endtask

    task automatic test_perf();
        sb_t         item;
        logic [CNT_W-1:0] expCnt;
`ifdef HAZARD_PERF_EN
        expCnt = CNT_W'(1);
`else
        expCnt = '0;
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            setIdle();
            case (k)
                0: begin reset = 1; applyStimulus("perf_reset", FRZ, FULL); end
                1: begin reset = 0; applyStimulus("perf_release", ALL1, FULL); end
                2: begin ihit = 0; applyStimulus("perf_miss", MISS, FULL); end
                default: applyStimulus("perf_idle", ALL1, FULL);
            endcase
            #2;
            item = sb.pop_front();
            nTests++;
            if ((obs & item.mask) !== (item.exp & item.mask)) begin
                nFail++;
                $display("[TB] FAIL %s: observed %b expected %b", item.name, obs & item.mask, item.exp & item.mask);
            end
        end
        nTests++;
        if (stallCnt !== expCnt || flushCnt !== expCnt) begin
            nFail++;
            $display("[TB] FAIL perf_counts: observed %0d/%0d expected %0d/%0d", stallCnt, flushCnt, expCnt, expCnt);
        end
    endtask

    initial begin
        setIdle();
        test_reset();
        test_normal();
        test_load_use();
        test_zero_reg();
        test_imiss();
        test_dwait();
        test_branch_lu();
        test_dwait_branch();
        test_reset_midway();
        test_timeout();
        test_halt_reset();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
